// File: rtl/integer_alu_issue_pkg.sv
// Shared constants and types for the integer ALU issue stage and the ALU.
package integer_alu_issue_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned RD_W     = 5;

  // ALU operation codes; bit 0 only distinguishes add/sub and srl/sra.
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1011;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b1100;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b1110;

  // RV32I major opcodes handled by this stage.
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Fully decoded entry as stored in the skid buffer.
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [RD_W-1:0]     rd;
    logic                we;
    logic                illegal;
  } issue_entry_t;

endpackage

// File: rtl/integer_alu_issue_alu_decode.sv
// Combinational decode of an RV32I OP / OP-IMM instruction into ALU fields.
module alu_decode
  import integer_alu_issue_pkg::*;
(
  input  logic [31:0]   inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_entry_t  entry_c
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       op_b;
  logic       illegal;
  logic       unused_rs1_field;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Register file already resolved rs1; the field itself is not needed here.
  assign unused_rs1_field = ^inst[19:15];

  // Operation, operand B and legality per major opcode.
  always_comb begin
    entry_c = '0;
    op_b    = 1'b0;
    illegal = 1'b0;
    entry_c.b = rs2_data;
    case (opcode)
      OPC_OP: begin
        op_b = inst[30];
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
        if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          entry_c.b = XLEN'(inst[24:20]);
        end else begin
          entry_c.b = XLEN'(signed'(inst[31:20]));
        end
        // Only shifts use inst[30]; otherwise ADDI with imm[10] set would become sub.
        if (funct3 == 3'b101) op_b = inst[30];
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    entry_c.op      = {funct3, op_b};
    entry_c.a       = rs1_data;
    entry_c.rd      = inst[11:7];
    entry_c.illegal = illegal;
    entry_c.we      = !illegal && (inst[11:7] != 5'd0);
  end

endmodule

// File: rtl/integer_alu_issue.sv
// Issue stage: decode ahead of a 2-entry skid buffer feeding the integer ALU.
module integer_alu_issue
  import integer_alu_issue_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INST,
  input  logic [WIDTH-1:0] RS1_DATA,
  input  logic [WIDTH-1:0] RS2_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [3:0]       OUT_OP,
  output logic [WIDTH-1:0] OUT_A,
  output logic [WIDTH-1:0] OUT_B,
  output logic [4:0]       OUT_RD,
  output logic             OUT_WE,
  output logic             OUT_ILLEGAL
);

  buf_state_e   state_q, state_d;
  issue_entry_t main_q, main_d;
  issue_entry_t skid_q, skid_d;
  issue_entry_t dec_entry;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         acc;
  logic         pop;

  alu_decode u_decode (
    .inst     (INST),
    .rs1_data (RS1_DATA),
    .rs2_data (RS2_DATA),
    .entry_c  (dec_entry)
  );

  // Buffer FSM: next state, entry movement and registered handshake flags.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    acc     = IN_VALID && in_ready_q;
    pop     = out_valid_q && OUT_READY;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_d  = dec_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            main_d = dec_entry;
          end else if (acc) begin
            skid_d  = dec_entry;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and entry registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY    = in_ready_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_OP      = main_q.op;
  assign OUT_A       = main_q.a;
  assign OUT_B       = main_q.b;
  assign OUT_RD      = main_q.rd;
  assign OUT_WE      = main_q.we;
  assign OUT_ILLEGAL = main_q.illegal;

endmodule

// File: tb/tb_integer_alu_issue.sv
// Directed self-checking bench for integer_alu_issue.
module tb_integer_alu_issue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INST;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [3:0]  OUT_OP;
  logic [31:0] OUT_A;
  logic [31:0] OUT_B;
  logic [4:0]  OUT_RD;
  logic        OUT_WE;
  logic        OUT_ILLEGAL;

  int total = 0;
  int bad   = 0;

  integer_alu_issue #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INST(INST), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_OP(OUT_OP), .OUT_A(OUT_A), .OUT_B(OUT_B),
    .OUT_RD(OUT_RD), .OUT_WE(OUT_WE), .OUT_ILLEGAL(OUT_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Offer one instruction for one edge; returns at the following negedge.
  task automatic issue_one(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    @(negedge CLK);
    INST = inst; RS1_DATA = rs1; RS2_DATA = rs2; IN_VALID = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0", IN_READY, OUT_VALID);
    end
    total++;
    if ({OUT_OP, OUT_A, OUT_B, OUT_RD, OUT_WE, OUT_ILLEGAL} !== '0) begin
      bad++; $display("FAIL reset_fields got op=%h a=%h b=%h rd=%0d we=%b ill=%b exp all 0",
                      OUT_OP, OUT_A, OUT_B, OUT_RD, OUT_WE, OUT_ILLEGAL);
    end
  endtask

  task automatic test_op();
    OUT_READY = 1'b1;
    issue_one(32'h002081B3, 32'd5, 32'd7);
    total++;
    if ({OUT_VALID, OUT_OP, OUT_A, OUT_B, OUT_RD, OUT_WE, OUT_ILLEGAL} !==
        {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add got v=%b op=%h a=%h b=%h rd=%0d we=%b ill=%b exp v=1 op=0 a=5 b=7 rd=3 we=1 ill=0",
                      OUT_VALID, OUT_OP, OUT_A, OUT_B, OUT_RD, OUT_WE, OUT_ILLEGAL);
    end
    issue_one(32'h402081B3, 32'd9, 32'd4);
    total++;
    if (OUT_OP !== 4'b0001 || OUT_ILLEGAL !== 1'b0 || OUT_B !== 32'd4) begin
      bad++; $display("FAIL sub got op=%h ill=%b b=%h exp op=1 ill=0 b=4", OUT_OP, OUT_ILLEGAL, OUT_B);
    end
    issue_one(32'h0020E1B3, 32'd1, 32'd2);
    total++;
    if (OUT_OP !== 4'b1100 || OUT_WE !== 1'b1) begin
      bad++; $display("FAIL or got op=%h we=%b exp op=c we=1", OUT_OP, OUT_WE);
    end
    issue_one(32'h00208033, 32'd1, 32'd2);
    total++;
    if (OUT_WE !== 1'b0 || OUT_ILLEGAL !== 1'b0 || OUT_RD !== 5'd0) begin
      bad++; $display("FAIL add_x0 got we=%b ill=%b rd=%0d exp we=0 ill=0 rd=0", OUT_WE, OUT_ILLEGAL, OUT_RD);
    end
  endtask

  task automatic test_opimm();
    OUT_READY = 1'b1;
    issue_one(32'h40008093, 32'd3, 32'hDEAD);
    total++;
    if (OUT_OP !== 4'b0000 || OUT_B !== 32'h00000400 || OUT_A !== 32'd3 || OUT_RD !== 5'd1) begin
      bad++; $display("FAIL addi_400 got op=%h b=%h a=%h rd=%0d exp op=0 b=400 a=3 rd=1", OUT_OP, OUT_B, OUT_A, OUT_RD);
    end
    issue_one(32'hFFF00293, 32'd0, 32'd0);
    total++;
    if (OUT_B !== 32'hFFFFFFFF || OUT_RD !== 5'd5 || OUT_WE !== 1'b1) begin
      bad++; $display("FAIL addi_m1 got b=%h rd=%0d we=%b exp b=ffffffff rd=5 we=1", OUT_B, OUT_RD, OUT_WE);
    end
    issue_one(32'h4030D113, 32'h80000000, 32'd0);
    total++;
    if (OUT_OP !== 4'b1011 || OUT_B !== 32'd3 || OUT_ILLEGAL !== 1'b0 || OUT_WE !== 1'b1) begin
      bad++; $display("FAIL srai got op=%h b=%h ill=%b we=%b exp op=b b=3 ill=0 we=1", OUT_OP, OUT_B, OUT_ILLEGAL, OUT_WE);
    end
    issue_one(32'h4000C093, 32'd0, 32'd0);
    total++;
    if (OUT_OP !== 4'b1000 || OUT_B !== 32'h00000400) begin
      bad++; $display("FAIL xori_b30 got op=%h b=%h exp op=8 b=400", OUT_OP, OUT_B);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] vec [4] = '{32'h40309113, 32'h022081B3, 32'h402091B3, 32'h00000003};
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_one(vec[i], 32'd1, 32'd2);
      total++;
      if (OUT_VALID !== 1'b1 || OUT_ILLEGAL !== 1'b1 || OUT_WE !== 1'b0) begin
        bad++; $display("FAIL illegal_%0d inst=%h got v=%b ill=%b we=%b exp v=1 ill=1 we=0",
                        i, vec[i], OUT_VALID, OUT_ILLEGAL, OUT_WE);
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx  = 0;
    int pops = 0;
    logic accd;
    OUT_READY = 1'b0;
    // Stall phase: only two entries fit.
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      INST = 32'h00208033 | (32'(idx + 1) << 7);
      RS1_DATA = 32'(10 + idx); RS2_DATA = 32'd0;
      accd = IN_READY;
      @(posedge CLK);
      if (accd) idx++;
    end
    @(negedge CLK);
    total++;
    if (idx !== 2 || IN_READY !== 1'b0) begin
      bad++; $display("FAIL bp_full got accepted=%0d rdy=%b exp accepted=2 rdy=0", idx, IN_READY);
    end
    total++;
    if (OUT_VALID !== 1'b1 || OUT_RD !== 5'd1 || OUT_A !== 32'd10) begin
      bad++; $display("FAIL bp_hold got v=%b rd=%0d a=%0d exp v=1 rd=1 a=10", OUT_VALID, OUT_RD, OUT_A);
    end
    // Release: drain in order while feeding the remaining two.
    OUT_READY = 1'b1;
    for (int c = 0; c < 20 && pops < 4; c++) begin
      if (OUT_VALID) begin
        total++;
        if (OUT_RD !== 5'(pops + 1) || OUT_A !== 32'(10 + pops)) begin
          bad++; $display("FAIL bp_order_%0d got rd=%0d a=%0d exp rd=%0d a=%0d",
                          pops, OUT_RD, OUT_A, pops + 1, 10 + pops);
        end
        pops++;
      end
      IN_VALID = (idx < 4);
      INST = 32'h00208033 | (32'(idx + 1) << 7);
      RS1_DATA = 32'(10 + idx);
      accd = IN_VALID && IN_READY;
      @(posedge CLK);
      if (accd) idx++;
      #1 IN_VALID = 1'b0;
      @(negedge CLK);
    end
    total++;
    if (pops !== 4 || idx !== 4 || OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL bp_drain got pops=%0d accepted=%0d v=%b exp pops=4 accepted=4 v=0", pops, idx, OUT_VALID);
    end
  endtask

  task automatic test_flush();
    OUT_READY = 1'b0;
    issue_one(32'h002081B3, 32'd1, 32'd1);
    issue_one(32'h002081B3, 32'd2, 32'd2);
    total++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
      bad++; $display("FAIL flush_pre got rdy=%b v=%b exp rdy=0 v=1", IN_READY, OUT_VALID);
    end
    FLUSH = 1'b1; IN_VALID = 1'b1; INST = 32'h002081B3;
    @(negedge CLK);
    total++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      bad++; $display("FAIL flush_two got v=%b rdy=%b exp v=0 rdy=1", OUT_VALID, IN_READY);
    end
    // Flush while empty and ready: the offered input is dropped.
    @(negedge CLK);
    total++;
    if (OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL flush_drop got v=%b exp v=0", OUT_VALID);
    end
    FLUSH = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    total++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      bad++; $display("FAIL flush_after got v=%b rdy=%b exp v=0 rdy=1", OUT_VALID, IN_READY);
    end
  endtask

  task automatic test_rst_mid();
    OUT_READY = 1'b0;
    issue_one(32'h002081B3, 32'd5, 32'd7);
    issue_one(32'h002081B3, 32'd6, 32'd8);
    RST = 1'b1;
    #1;
    total++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || OUT_A !== 32'd0 || OUT_RD !== 5'd0) begin
      bad++; $display("FAIL rst_async got v=%b rdy=%b a=%h rd=%0d exp v=0 rdy=1 a=0 rd=0",
                      OUT_VALID, IN_READY, OUT_A, OUT_RD);
    end
    #2 RST = 1'b0;
    @(negedge CLK);
    total++;
    if (OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL rst_stays got v=%b exp v=0", OUT_VALID);
    end
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    INST = '0; RS1_DATA = '0; RS2_DATA = '0;
    #12;
    test_reset();
    RST = 1'b0;
    test_op();
    test_opimm();
    test_illegal();
    do_reset();
    test_back_to_back();
    do_reset();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got no finish exp finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
